wheel_config: RTL and testbench
===============================

# wheel_config

Parametrised wheel-circumference entry unit for the cycle computer. The rider enters the wheel diameter as N decimal digits (mm) with the nTrip/nMode buttons. On commit, the block converts BCD to binary over several cycles, then multiplies by π with a sequential shift-add multiplier. The committed circumference is held on `perimeter`, in mm, for the distance/speed datapath. Unlike the single-cycle three-digit predecessor, this block:
- detects button edges;
- supports cancel with restore;
- rejects a zero diameter;
- keeps the last valid perimeter while a new one is computed.

## Interface
Parameters:
- NDIGITS, 3: number of BCD diameter digits, 1..6.
- OUT_W, 32: `perimeter` width.
- DEFAULT_CIRC, 2136: `perimeter` value after reset, in mm.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- nRst  in  1  asynchronous active-low reset.
- nTrip  in  1  active-low button, already debounced and synchronous; increments the selected digit.
- nMode  in  1  active-low button, already debounced and synchronous; advances the cursor or commits.
- ws_en  in  1  level; enters edit mode from IDLE.
- digits  out  4*NDIGITS  BCD digits being edited; digit 0 is the MSD at the top nibble.
- cursor  out  $clog2(NDIGITS+1)  index of the selected digit, 0 = MSD.
- editing  out  1  high in EDIT.
- perimeter  out  OUT_W  committed circumference in mm, integer.
- ready  out  1  high when `perimeter` is stable (not CONVERT/MULT/COMMIT).
- err  out  1  one-cycle pulse when a zero diameter is rejected.

## Operation
- Press detection:
  - Registered copies of nTrip and nMode give a press when the button is now low and was high last cycle.
  - Holding a button produces one press only.
- Cancel = both buttons sampled low in a cycle where at least one of them has a press.
- States: IDLE, EDIT, CONVERT, MULT, COMMIT.
- IDLE:
  - `ws_en` high → EDIT with cursor = 0.
  - The working digits copy the committed digits; after reset these are all 0.
  - Buttons are otherwise ignored.
- EDIT:
  - nTrip press (no cancel) → digit[cursor] + 1, wrapping 9→0.
  - nMode press (no cancel) with cursor < NDIGITS-1 → cursor + 1.
  - nMode press with cursor = NDIGITS-1 → CONVERT.
  - Cancel → IDLE; working digits restored to committed; `perimeter` unchanged.
  - `ws_en` is ignored in EDIT.
- CONVERT:
  - dia_acc starts at 0; each cycle dia_acc = dia_acc*10 + digit[i], for i = 0..NDIGITS-1.
  - Takes NDIGITS cycles.
- Zero check:
  - At the end of CONVERT, if dia_acc = 0 → pulse `err`, restore the digits, go to IDLE, leave `perimeter` unchanged.
  - Otherwise go to MULT.
- MULT:
  - 24-cycle shift-add of dia_acc × PI_Q22, one multiplier bit per cycle, LSB first.
- COMMIT:
  - `perimeter` = product >> 22, truncated (floor).
  - If the result exceeds 2^OUT_W-1 it saturates to all ones.
  - The committed digits take the working digits; then go to IDLE.
- Widths:
  - DW = $clog2(10^NDIGITS).
  - Product width = DW+24.
  - All intermediate arithmetic is unsigned and never truncates before COMMIT.
- Buttons are ignored in CONVERT, MULT and COMMIT, including cancel.
- `ready` = 0 in CONVERT, MULT and COMMIT; 1 otherwise.

## Timing
- Reset values:
  - state = IDLE; digits = 0; cursor = 0; editing = 0.
  - perimeter = DEFAULT_CIRC; ready = 1; err = 0; button history = released.
- Press sampled at edge k (final nMode):
  - CONVERT occupies k+1 .. k+NDIGITS.
  - MULT occupies the next 24 cycles.
  - COMMIT is one cycle.
  - New `perimeter` is visible and `ready` = 1 after edge k+NDIGITS+26.
  - Total latency NDIGITS+26 cycles.
- The old `perimeter` is held unchanged until the COMMIT edge; there are no intermediate values.
- Zero-diameter path: `err` is high for the one cycle after the last CONVERT edge, and `ready` returns to 1 in that same cycle.
- Reset asserted mid-CONVERT/MULT aborts the operation: all outputs take their reset values asynchronously.

## Structure
- Package `wheel_pkg`:
  - PI_Q22 = 24'hC90FDB (π in Q2.22).
  - PI_W = 24.
  - PI_FRAC = 22.
  - state enum typedef `wc_state_t`.
- Sub-module `shift_add_mult`:
  - Ports: start, operand a (DW bits), constant b (PI_W bits), done, product (DW+PI_W bits).
  - Fixed PI_W-cycle latency.

## Test plan
- Reset → perimeter = 2136, ready = 1, digits = 000, err = 0.
- ws_en, nTrip ×6 (digit0 = 6), nMode, nTrip ×8, nMode, nTrip ×6, nMode → ready low for 28 cycles, then perimeter = 2155 (686 mm × π floor).
- Hold nTrip low for 10 cycles in EDIT → digit increments once only. Then 10 separate presses → digit wraps back to its original value.
- Enter 5,0,0, then cancel (both pressed together) at the cursor-2 digit → IDLE, perimeter unchanged, digits restored to committed values.
- Commit 000 → err pulses one cycle, perimeter unchanged, ready back high, no MULT cycles.
- Assert nRst during MULT → immediate reset values; the next full entry of 700 commits perimeter = 2199.

Source files
------------

// File: rtl/wheel_pkg.sv
// Shared constants and state type for the wheel-circumference entry unit.
package wheel_pkg;
  localparam int PI_W    = 24;
  localparam int PI_FRAC = 22;
  localparam logic [PI_W-1:0] PI_Q22 = 24'hC90FDB;  // pi in Q2.22

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EDIT,
    ST_CONVERT,
    ST_MULT,
    ST_COMMIT
  } wc_state_t;
endpackage

// File: rtl/wheel_config_mult.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, LSB first,
// fixed BW-cycle latency after start_i.
module shift_add_mult
  import wheel_pkg::*;
#(
  parameter int AW = 10,
  parameter int BW = PI_W
) (
  input  logic             clock,
  input  logic             nRst,
  input  logic             start_i,
  input  logic [AW-1:0]    a_i,
  input  logic [BW-1:0]    b_i,
  output logic             done_o,
  output logic [AW+BW-1:0] product_o
);
  localparam int PW    = AW + BW;
  localparam int CNT_W = $clog2(BW);

  logic [PW-1:0]    mcand_q, mcand_d, prod_q, prod_d;
  logic [BW-1:0]    mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start_i) begin
      mcand_d  = PW'(a_i);
      mplier_d = b_i;
      prod_d   = '0;
      cnt_d    = CNT_W'(BW - 1);
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) prod_d = prod_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      if (cnt_q == '0) busy_d = 1'b0;
      else             cnt_d  = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge nRst) begin
    if (!nRst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  // done marks the cycle whose edge performs the final partial-product add
  assign done_o    = busy_q && (cnt_q == '0);
  assign product_o = prod_q;
endmodule

// File: rtl/wheel_config.sv
// Wheel diameter entry (BCD digits) and circumference = floor(dia * pi).
// state      | meaning
// IDLE       | working digits track committed digits; wait for ws_en
// EDIT       | buttons edit digit[cursor] / advance cursor / cancel
// CONVERT    | BCD to binary, one digit per cycle, MSD first
// MULT       | shift-add dia * PI_Q22, 24 cycles
// COMMIT     | latch saturated circumference and committed digits
module wheel_config
  import wheel_pkg::*;
#(
  parameter int          NDIGITS      = 3,
  parameter int          OUT_W        = 32,
  parameter int unsigned DEFAULT_CIRC = 2136
) (
  input  logic                         clock,
  input  logic                         nRst,
  input  logic                         nTrip,
  input  logic                         nMode,
  input  logic                         ws_en,
  output logic [4*NDIGITS-1:0]         digits,
  output logic [$clog2(NDIGITS+1)-1:0] cursor,
  output logic                         editing,
  output logic [OUT_W-1:0]             perimeter,
  output logic                         ready,
  output logic                         err
);
  localparam int DW    = $clog2(10**NDIGITS);
  localparam int PW    = DW + PI_W;
  localparam int SW    = PW - PI_FRAC;
  localparam int CW    = (SW > OUT_W) ? SW : OUT_W;
  localparam int CUR_W = $clog2(NDIGITS+1);

  wc_state_t                   state_q, state_d;
  logic                        trip_q, trip_q2, mode_q, mode_q2;
  logic [NDIGITS-1:0][3:0]     dig_q, dig_d, cdig_q, cdig_d;
  logic [CUR_W-1:0]            cursor_q, cursor_d, conv_q, conv_d, sel;
  logic [DW-1:0]               dia_q, dia_d, dia_next;
  logic [OUT_W-1:0]            perim_q, perim_d, perim_sat;
  logic                        err_q, err_d;
  logic                        trip_press, mode_press, cancel;
  logic                        mult_start, mult_done;
  logic [PW-1:0]               product;
  logic [CW-1:0]               shr_w;

  assign trip_press = !trip_q && trip_q2;
  assign mode_press = !mode_q && mode_q2;
  assign cancel     = !trip_q && !mode_q && (trip_press || mode_press);

  // digit 0 (MSD) lives in the top packed element
  assign sel      = CUR_W'(NDIGITS - 1) - cursor_q;
  assign dia_next = (dia_q * DW'(10)) + DW'(dig_q[conv_q]);

  assign shr_w     = CW'(product >> PI_FRAC);
  assign perim_sat = (shr_w > CW'({OUT_W{1'b1}})) ? '1 : OUT_W'(shr_w);

  shift_add_mult #(.AW(DW), .BW(PI_W)) u_mult (
    .clock     (clock),
    .nRst      (nRst),
    .start_i   (mult_start),
    .a_i       (dia_next),
    .b_i       (PI_Q22),
    .done_o    (mult_done),
    .product_o (product)
  );

  always_comb begin
    state_d    = state_q;
    dig_d      = dig_q;
    cdig_d     = cdig_q;
    cursor_d   = cursor_q;
    conv_d     = conv_q;
    dia_d      = dia_q;
    perim_d    = perim_q;
    err_d      = 1'b0;
    mult_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        dig_d = cdig_q;
        if (ws_en) begin
          state_d  = ST_EDIT;
          cursor_d = '0;
        end
      end
      ST_EDIT: begin
        if (cancel) begin
          dig_d   = cdig_q;
          state_d = ST_IDLE;
        end else begin
          if (trip_press) dig_d[sel] = (dig_q[sel] == 4'd9) ? 4'd0 : dig_q[sel] + 4'd1;
          if (mode_press) begin
            if (cursor_q < CUR_W'(NDIGITS - 1)) begin
              cursor_d = cursor_q + CUR_W'(1);
            end else begin
              state_d = ST_CONVERT;
              conv_d  = CUR_W'(NDIGITS - 1);
              dia_d   = '0;
            end
          end
        end
      end
      ST_CONVERT: begin
        dia_d = dia_next;
        if (conv_q == '0) begin
          if (dia_next == '0) begin
            err_d   = 1'b1;
            dig_d   = cdig_q;
            state_d = ST_IDLE;
          end else begin
            mult_start = 1'b1;
            state_d    = ST_MULT;
          end
        end else begin
          conv_d = conv_q - CUR_W'(1);
        end
      end
      ST_MULT: if (mult_done) state_d = ST_COMMIT;
      ST_COMMIT: begin
        perim_d = perim_sat;
        cdig_d  = dig_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nRst) begin
    if (!nRst) begin
      state_q  <= ST_IDLE;
      trip_q   <= 1'b1;
      trip_q2  <= 1'b1;
      mode_q   <= 1'b1;
      mode_q2  <= 1'b1;
      dig_q    <= '0;
      cdig_q   <= '0;
      cursor_q <= '0;
      conv_q   <= '0;
      dia_q    <= '0;
      perim_q  <= OUT_W'(DEFAULT_CIRC);
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      trip_q   <= nTrip;
      trip_q2  <= trip_q;
      mode_q   <= nMode;
      mode_q2  <= mode_q;
      dig_q    <= dig_d;
      cdig_q   <= cdig_d;
      cursor_q <= cursor_d;
      conv_q   <= conv_d;
      dia_q    <= dia_d;
      perim_q  <= perim_d;
      err_q    <= err_d;
    end
  end

  assign digits    = dig_q;
  assign cursor    = cursor_q;
  assign editing   = (state_q == ST_EDIT);
  assign perimeter = perim_q;
  assign ready     = !(state_q inside {ST_CONVERT, ST_MULT, ST_COMMIT});
  assign err       = err_q;
endmodule

// File: tb/tb_wheel_config.sv
// Self-checking bench for wheel_config: directed scenarios plus random button
// traffic, compared every cycle against a behavioural model.
module tb_wheel_config;
  localparam int N     = 3;
  localparam int OUT_W = 32;

  logic              clock = 1'b0;
  logic              nRst  = 1'b0;
  logic              nTrip = 1'b1;
  logic              nMode = 1'b1;
  logic              ws_en = 1'b0;
  logic [4*N-1:0]    digits;
  logic [1:0]        cursor;
  logic              editing;
  logic [OUT_W-1:0]  perimeter;
  logic              ready;
  logic              err;

  int checks = 0;
  int errors = 0;

  wheel_config #(.NDIGITS(N), .OUT_W(OUT_W), .DEFAULT_CIRC(2136)) dut (
    .clock(clock), .nRst(nRst), .nTrip(nTrip), .nMode(nMode), .ws_en(ws_en),
    .digits(digits), .cursor(cursor), .editing(editing),
    .perimeter(perimeter), .ready(ready), .err(err)
  );

  always #5 clock = ~clock;

  // behavioural model: digits as integers, busy time as a plain countdown
  int     m_dig[N];
  int     m_cdig[N];
  int     m_cursor;
  bit     m_edit;
  int     m_busy;
  bit     m_zero;
  longint m_pend;
  longint m_perim;
  bit     m_err;
  bit     mt_q, mt_q2, mm_q, mm_q2;

  function automatic longint circ(input int dia);
    longint p;
    p = (longint'(dia) * longint'(24'hC90FDB)) >> 22;
    if (p > ((64'd1 << OUT_W) - 1)) p = (64'd1 << OUT_W) - 1;
    return p;
  endfunction

  task automatic reset_model();
    for (int i = 0; i < N; i++) begin m_dig[i] = 0; m_cdig[i] = 0; end
    m_cursor = 0; m_edit = 0; m_busy = 0; m_zero = 0; m_pend = 0;
    m_perim = 2136; m_err = 0;
    mt_q = 1; mt_q2 = 1; mm_q = 1; mm_q2 = 1;
  endtask

  task automatic model_step();
    bit tp, mp, cancel;
    int dia;
    tp = !mt_q && mt_q2;
    mp = !mm_q && mm_q2;
    cancel = !mt_q && !mm_q && (tp || mp);
    m_err = 0;
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        if (m_zero) begin m_err = 1; m_dig = m_cdig; end
        else begin m_perim = m_pend; m_cdig = m_dig; end
      end
    end else if (m_edit) begin
      if (cancel) begin
        m_edit = 0; m_dig = m_cdig;
      end else begin
        if (tp) m_dig[m_cursor] = (m_dig[m_cursor] + 1) % 10;
        if (mp) begin
          if (m_cursor < N - 1) m_cursor++;
          else begin
            m_edit = 0;
            dia = 0;
            for (int i = 0; i < N; i++) dia = dia * 10 + m_dig[i];
            m_zero = (dia == 0);
            m_pend = circ(dia);
            m_busy = m_zero ? N : N + 25;
          end
        end
      end
    end else begin
      m_dig = m_cdig;
      if (ws_en) begin m_edit = 1; m_cursor = 0; end
    end
    mt_q2 = mt_q; mt_q = nTrip;
    mm_q2 = mm_q; mm_q = nMode;
  endtask

  initial begin
    reset_model();
    forever begin
      @(posedge clock or negedge nRst);
      if (!nRst) reset_model();
      else model_step();
    end
  end

  function automatic logic [4*N-1:0] exp_digits();
    logic [4*N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[4*(N-1-i) +: 4] = 4'(m_dig[i]);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (nRst) begin
      chk("digits",    64'(digits),    64'(exp_digits()));
      chk("cursor",    64'(cursor),    64'(m_cursor));
      chk("editing",   64'(editing),   64'(m_edit));
      chk("perimeter", 64'(perimeter), 64'(m_perim));
      chk("ready",     64'(ready),     64'(m_busy == 0));
      chk("err",       64'(err),       64'(m_err));
    end
  end

  task automatic drive(input bit t, input bit m, input int n);
    nTrip = t; nMode = m;
    repeat (n) @(negedge clock);
  endtask

  task automatic press_trip(input int k);
    repeat (k) begin drive(0, 1, 1); drive(1, 1, 1); end
  endtask

  task automatic press_mode();
    drive(1, 0, 1); drive(1, 1, 1);
  endtask

  task automatic enter_edit();
    ws_en = 1; @(negedge clock);
    ws_en = 0; @(negedge clock);
  endtask

  // final nMode press, then count cycles with ready low until it returns
  task automatic commit_measure(output int low, output bit saw_err);
    bit started, done;
    low = 0; saw_err = 0; started = 0; done = 0;
    drive(1, 0, 1);
    nMode = 1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clock);
      if (err) saw_err = 1;
      if (!ready) begin low++; started = 1; end
      else if (started) done = 1;
    end
    if (!done) chk("commit_timeout", 64'(done), 64'd1);
  endtask

  int lowc;
  bit serr;

  initial begin
    repeat (3) @(negedge clock);
    #1;
    chk("rst_perimeter", 64'(perimeter), 64'd2136);
    chk("rst_ready",     64'(ready),     64'd1);
    chk("rst_digits",    64'(digits),    64'h000);
    chk("rst_err",       64'(err),       64'd0);
    @(negedge clock);
    nRst = 1;
    @(negedge clock);

    // 686 mm
    enter_edit();
    press_trip(6); press_mode();
    press_trip(8); press_mode();
    press_trip(6);
    commit_measure(lowc, serr);
    chk("ready_low_686", 64'(lowc), 64'(N + 25));
    chk("perim_686",     64'(perimeter), 64'd2155);
    chk("model_686",     64'(m_perim),   64'd2155);
    chk("digits_686",    64'(digits),    64'h686);

    // held button counts once, ten presses wrap back
    enter_edit();
    drive(0, 1, 10); drive(1, 1, 2);
    chk("hold_once", 64'(digits), 64'h786);
    press_trip(10);
    chk("wrap10", 64'(digits), 64'h786);
    press_trip(9);
    chk("wrap_back", 64'(digits), 64'h686);
    drive(0, 0, 1); drive(1, 1, 2);
    chk("cancel1_edit", 64'(editing), 64'd0);

    // 5,0,0 then cancel at cursor 2
    enter_edit();
    press_trip(9); press_mode();
    press_trip(2); press_mode();
    press_trip(4);
    chk("pre_cancel_digits", 64'(digits), 64'h500);
    chk("pre_cancel_cursor", 64'(cursor), 64'd2);
    drive(0, 0, 1); drive(1, 1, 2);
    chk("cancel_digits",  64'(digits),    64'h686);
    chk("cancel_perim",   64'(perimeter), 64'd2155);
    chk("cancel_editing", 64'(editing),   64'd0);

    // zero diameter rejected
    enter_edit();
    press_trip(4); press_mode();
    press_trip(2); press_mode();
    press_trip(4);
    commit_measure(lowc, serr);
    chk("zero_low",   64'(lowc), 64'(N));
    chk("zero_err",   64'(serr), 64'd1);
    chk("zero_perim", 64'(perimeter), 64'd2155);
    chk("zero_ready", 64'(ready), 64'd1);
    @(negedge clock);
    chk("zero_err_once", 64'(err),    64'd0);
    chk("zero_digits",   64'(digits), 64'h686);

    // reset during MULT
    enter_edit();
    press_trip(1); press_mode();
    press_trip(2); press_mode();
    press_trip(4);
    drive(1, 0, 1);
    nMode = 1;
    repeat (8) @(negedge clock);
    chk("in_mult_ready", 64'(ready), 64'd0);
    #2 nRst = 0;
    #1;
    chk("mrst_perim",   64'(perimeter), 64'd2136);
    chk("mrst_ready",   64'(ready),     64'd1);
    chk("mrst_digits",  64'(digits),    64'h000);
    chk("mrst_editing", 64'(editing),   64'd0);
    repeat (2) @(negedge clock);
    nRst = 1;
    @(negedge clock);
    enter_edit();
    press_trip(7); press_mode(); press_mode();
    commit_measure(lowc, serr);
    chk("ready_low_700", 64'(lowc), 64'(N + 25));
    chk("perim_700",     64'(perimeter), 64'd2199);
    chk("model_700",     64'(m_perim),   64'd2199);

    // random button traffic
    for (int c = 0; c < 3000; c++) begin
      ws_en = ($urandom_range(0, 7) == 0);
      nTrip = ($urandom_range(0, 2) != 0);
      nMode = ($urandom_range(0, 3) != 0);
      @(negedge clock);
    end
    nTrip = 1; nMode = 1; ws_en = 0;
    repeat (40) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end
endmodule
